// File: rtl/branch_predictor_btb.sv
// branch_predictor_btb
//   Branch target buffer with saturating-counter direction prediction.
//   Fetch looks up i_pc_f combinationally and gets a predicted-taken flag and
//   target. Execute reports each resolved control transfer. The block then
//   trains its table and counts resolved branches and mispredictions.
//
// Ports
//   i_clk, i_rst                 clock (rising edge), synchronous active-high reset
//   i_pc_f                       fetch PC to look up
//   o_pred_taken, o_pred_target  prediction for i_pc_f (target is 0 when not taken)
//   i_upd_vld, i_upd_pc          resolved insn valid and its PC
//   i_upd_taken, i_upd_target    actual outcome and target
//   i_upd_pred                   prediction that travelled with the insn
//   o_br_cnt, o_miss_cnt         saturating resolved-branch and mispredict counts
//
// Configuration
//   BP_GSHARE_EN  when defined, the counter row is bidx XOR global history.
//                 Valid, tag and target always use bidx.
module branch_predictor_btb #(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 16,
    parameter int CNT_W   = 2,
    parameter int GHR_W   = 4
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [XLEN-1:0] i_pc_f,
    output logic            o_pred_taken,
    output logic [XLEN-1:0] o_pred_target,
    input  logic            i_upd_vld,
    input  logic [XLEN-1:0] i_upd_pc,
    input  logic            i_upd_taken,
    input  logic [XLEN-1:0] i_upd_target,
    input  logic            i_upd_pred,
    output logic [31:0]     o_br_cnt,
    output logic [31:0]     o_miss_cnt
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - 2 - IDX_W;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_WT  = CNT_W'(1 << (CNT_W - 1));
    localparam logic [CNT_W-1:0] CNT_WNT = CNT_W'((1 << (CNT_W - 1)) - 1);

    logic             r_valid  [ENTRIES];
    logic [TAG_W-1:0] r_tag    [ENTRIES];
    logic [XLEN-1:0]  r_target [ENTRIES];
    logic [CNT_W-1:0] r_cnt    [ENTRIES];
    logic [31:0]      r_br_cnt;
    logic [31:0]      r_miss_cnt;

    logic [IDX_W-1:0] w_lk_idx;
    logic [IDX_W-1:0] w_lk_cidx;
    logic [TAG_W-1:0] w_lk_tag;
    logic             w_lk_hit;
    logic [IDX_W-1:0] w_up_idx;
    logic [IDX_W-1:0] w_up_cidx;
    logic [TAG_W-1:0] w_up_tag;
    logic             w_up_hit;
    logic [CNT_W-1:0] w_up_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_miss;

    assign w_lk_idx = i_pc_f[IDX_W+1:2];
    assign w_lk_tag = i_pc_f[XLEN-1:IDX_W+2];
    assign w_up_idx = i_upd_pc[IDX_W+1:2];
    assign w_up_tag = i_upd_pc[XLEN-1:IDX_W+2];

`ifdef BP_GSHARE_EN
    logic [GHR_W-1:0] r_ghr;
    logic [IDX_W-1:0] w_ghr_ext;

    always_comb begin
        w_ghr_ext = '0;
        w_ghr_ext[GHR_W-1:0] = r_ghr;
    end

    // Lookup and update both see the history as it stands before this
    // cycle's shift.
    assign w_lk_cidx = w_lk_idx ^ w_ghr_ext;
    assign w_up_cidx = w_up_idx ^ w_ghr_ext;
`else
    logic [GHR_W-1:0] w_unused_ghr;
    assign w_unused_ghr = '0;
    assign w_lk_cidx    = w_lk_idx;
    assign w_up_cidx    = w_up_idx;
`endif

    // PC bits [1:0] never take part in indexing or tagging.
    logic w_unused;
    assign w_unused = ^{i_pc_f[1:0], i_upd_pc[1:0]};

    assign w_lk_hit = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
    assign w_up_hit = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);
    assign w_up_cnt = r_cnt[w_up_cidx];
    assign w_miss   = i_upd_taken != i_upd_pred;

    always_comb begin
        w_cnt_next = w_up_cnt;
        if (i_upd_taken) begin
            if (w_up_cnt != CNT_MAX) w_cnt_next = w_up_cnt + CNT_W'(1);
        end else begin
            if (w_up_cnt != '0) w_cnt_next = w_up_cnt - CNT_W'(1);
        end
    end

    assign o_pred_taken  = w_lk_hit && r_cnt[w_lk_cidx][CNT_W-1];
    assign o_pred_target = o_pred_taken ? r_target[w_lk_idx] : '0;
    assign o_br_cnt      = r_br_cnt;
    assign o_miss_cnt    = r_miss_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int k = 0; k < ENTRIES; k++) begin
                r_valid[k]  <= 1'b0;
                r_tag[k]    <= '0;
                r_target[k] <= '0;
                r_cnt[k]    <= CNT_WNT;
            end
            r_br_cnt   <= '0;
            r_miss_cnt <= '0;
`ifdef BP_GSHARE_EN
            r_ghr      <= '0;
`endif
        end else if (i_upd_vld) begin
            if (w_up_hit) begin
                r_cnt[w_up_cidx] <= w_cnt_next;
                if (i_upd_taken) r_target[w_up_idx] <= i_upd_target;
            end else if (i_upd_taken) begin
                // Allocation evicts whatever occupied the row.
                r_valid[w_up_idx]  <= 1'b1;
                r_tag[w_up_idx]    <= w_up_tag;
                r_target[w_up_idx] <= i_upd_target;
                r_cnt[w_up_cidx]   <= CNT_WT;
            end
            if (r_br_cnt != 32'hFFFF_FFFF) r_br_cnt <= r_br_cnt + 32'd1;
            if (w_miss && (r_miss_cnt != 32'hFFFF_FFFF)) r_miss_cnt <= r_miss_cnt + 32'd1;
`ifdef BP_GSHARE_EN
            // Truncating the concatenation keeps the newest GHR_W outcomes.
            r_ghr <= GHR_W'({r_ghr, i_upd_taken});
`endif
        end
    end

endmodule

// File: tb/tb_branch_predictor_btb.sv
module tb_branch_predictor_btb;

    logic        i_clk;
    logic        i_rst;
    logic [31:0] i_pc_f;
    logic        o_pred_taken;
    logic [31:0] o_pred_target;
    logic        i_upd_vld;
    logic [31:0] i_upd_pc;
    logic        i_upd_taken;
    logic [31:0] i_upd_target;
    logic        i_upd_pred;
    logic [31:0] o_br_cnt;
    logic [31:0] o_miss_cnt;

    int n_pass  = 0;
    int n_total = 0;

    branch_predictor_btb dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_pc_f       (i_pc_f),
        .o_pred_taken (o_pred_taken),
        .o_pred_target(o_pred_target),
        .i_upd_vld    (i_upd_vld),
        .i_upd_pc     (i_upd_pc),
        .i_upd_taken  (i_upd_taken),
        .i_upd_target (i_upd_target),
        .i_upd_pred   (i_upd_pred),
        .o_br_cnt     (o_br_cnt),
        .o_miss_cnt   (o_miss_cnt)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // One clock with i_rst high; returns 1 time unit after the edge.
    task automatic do_reset();
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
    endtask

    task automatic do_upd(input logic [31:0] pc, input logic taken,
                          input logic [31:0] tgt, input logic pred);
        i_upd_vld    = 1'b1;
        i_upd_pc     = pc;
        i_upd_taken  = taken;
        i_upd_target = tgt;
        i_upd_pred   = pred;
        @(posedge i_clk);
        #1;
        i_upd_vld = 1'b0;
    endtask

    task automatic look(input logic [31:0] pc);
        i_pc_f = pc;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        look(32'h100);
        n_total++;
        if (o_pred_taken !== 1'b0) $display("FAIL reset_taken got=%0b exp=0", o_pred_taken);
        else n_pass++;
        n_total++;
        if (o_pred_target !== 32'h0) $display("FAIL reset_target got=%h exp=0", o_pred_target);
        else n_pass++;
        n_total++;
        if (o_br_cnt !== 32'd0) $display("FAIL reset_br_cnt got=%0d exp=0", o_br_cnt);
        else n_pass++;
        n_total++;
        if (o_miss_cnt !== 32'd0) $display("FAIL reset_miss_cnt got=%0d exp=0", o_miss_cnt);
        else n_pass++;
    endtask

    // Continues from test_reset: first taken update allocates weakly taken.
    task automatic test_allocate();
        do_upd(32'h100, 1'b1, 32'h40, 1'b0);
        look(32'h100);
        n_total++;
        if (o_pred_taken !== 1'b1) $display("FAIL alloc_taken got=%0b exp=1", o_pred_taken);
        else n_pass++;
        n_total++;
        if (o_pred_target !== 32'h40) $display("FAIL alloc_target got=%h exp=40", o_pred_target);
        else n_pass++;
        n_total++;
        if (o_br_cnt !== 32'd1) $display("FAIL alloc_br_cnt got=%0d exp=1", o_br_cnt);
        else n_pass++;
        n_total++;
        if (o_miss_cnt !== 32'd1) $display("FAIL alloc_miss_cnt got=%0d exp=1", o_miss_cnt);
        else n_pass++;
    endtask

    // Counter path 2->3->3->2->1->0->0, then one taken back to 1.
    task automatic test_counter();
        logic        tk  [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic        prd [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [31:0] tg  [7] = '{32'h40, 32'h44, 32'h0, 32'h0, 32'h0, 32'h0, 32'h48};
        logic        exp [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 7; i++) begin
            do_upd(32'h100, tk[i], tg[i], prd[i]);
            look(32'h100);
            n_total++;
            if (o_pred_taken !== exp[i])
                $display("FAIL cnt_step%0d_taken got=%0b exp=%0b", i, o_pred_taken, exp[i]);
            else n_pass++;
            if (i == 1) begin
                n_total++;
                if (o_pred_target !== 32'h44)
                    $display("FAIL cnt_target_update got=%h exp=44", o_pred_target);
                else n_pass++;
            end
        end
        n_total++;
        if (o_pred_target !== 32'h0) $display("FAIL cnt_nt_target got=%h exp=0", o_pred_target);
        else n_pass++;
        n_total++;
        if (o_br_cnt !== 32'd8) $display("FAIL cnt_br_cnt got=%0d exp=8", o_br_cnt);
        else n_pass++;
        // Misses: initial alloc, two NT while predicting taken, final T while predicting NT.
        n_total++;
        if (o_miss_cnt !== 32'd4) $display("FAIL cnt_miss_cnt got=%0d exp=4", o_miss_cnt);
        else n_pass++;
    endtask

    task automatic test_alias();
        do_reset();
        do_upd(32'h100, 1'b1, 32'h40, 1'b0);
        do_upd(32'h140, 1'b1, 32'h80, 1'b0);
        look(32'h100);
        n_total++;
        if (o_pred_taken !== 1'b0) $display("FAIL alias_evicted_taken got=%0b exp=0", o_pred_taken);
        else n_pass++;
        n_total++;
        if (o_pred_target !== 32'h0) $display("FAIL alias_evicted_target got=%h exp=0", o_pred_target);
        else n_pass++;
        look(32'h140);
        n_total++;
        if (o_pred_target !== 32'h80) $display("FAIL alias_new_target got=%h exp=80", o_pred_target);
        else n_pass++;
        look(32'h143);
        n_total++;
        if (o_pred_target !== 32'h80) $display("FAIL alias_misaligned got=%h exp=80", o_pred_target);
        else n_pass++;
    endtask

    task automatic test_no_alloc();
        do_reset();
        do_upd(32'h300, 1'b0, 32'h500, 1'b0);
        look(32'h300);
        n_total++;
        if (o_pred_taken !== 1'b0) $display("FAIL noalloc_taken got=%0b exp=0", o_pred_taken);
        else n_pass++;
        n_total++;
        if (o_br_cnt !== 32'd1) $display("FAIL noalloc_br_cnt got=%0d exp=1", o_br_cnt);
        else n_pass++;
        n_total++;
        if (o_miss_cnt !== 32'd0) $display("FAIL noalloc_miss_cnt got=%0d exp=0", o_miss_cnt);
        else n_pass++;
        // A later taken update must still allocate cleanly.
        do_upd(32'h300, 1'b1, 32'h500, 1'b0);
        n_total++;
        if (o_pred_target !== 32'h500) $display("FAIL noalloc_then_alloc got=%h exp=500", o_pred_target);
        else n_pass++;
    endtask

    task automatic test_same_cycle();
        do_reset();
        i_pc_f       = 32'h200;
        i_upd_vld    = 1'b1;
        i_upd_pc     = 32'h200;
        i_upd_taken  = 1'b1;
        i_upd_target = 32'h300;
        i_upd_pred   = 1'b0;
        #1;
        n_total++;
        if (o_pred_taken !== 1'b0) $display("FAIL same_cycle_pre got=%0b exp=0", o_pred_taken);
        else n_pass++;
        @(posedge i_clk);
        #1;
        i_upd_vld = 1'b0;
        #1;
        n_total++;
        if (o_pred_target !== 32'h300) $display("FAIL same_cycle_post got=%h exp=300", o_pred_target);
        else n_pass++;
        // Reset wins over a simultaneous update.
        i_rst      = 1'b1;
        i_upd_vld  = 1'b1;
        i_upd_pc   = 32'h200;
        i_upd_pred = 1'b0;
        @(posedge i_clk);
        #1;
        i_rst     = 1'b0;
        i_upd_vld = 1'b0;
        #1;
        n_total++;
        if (o_pred_taken !== 1'b0) $display("FAIL rst_upd_taken got=%0b exp=0", o_pred_taken);
        else n_pass++;
        n_total++;
        if (o_br_cnt !== 32'd0) $display("FAIL rst_upd_br_cnt got=%0d exp=0", o_br_cnt);
        else n_pass++;
        n_total++;
        if (o_miss_cnt !== 32'd0) $display("FAIL rst_upd_miss_cnt got=%0d exp=0", o_miss_cnt);
        else n_pass++;
    endtask

    // Alternating T/NT at PC 0x100; the prediction before each update is checked.
    task automatic test_alternating();
`ifdef BP_GSHARE_EN
        logic        exp [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic        exp_final = 1'b1;
        logic [31:0] exp_miss  = 32'd3;
`else
        logic        exp [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic        exp_final = 1'b0;
        logic [31:0] exp_miss  = 32'd8;
`endif
        do_reset();
        for (int i = 0; i < 8; i++) begin
            look(32'h100);
            n_total++;
            if (o_pred_taken !== exp[i])
                $display("FAIL alt_pred%0d got=%0b exp=%0b", i, o_pred_taken, exp[i]);
            else n_pass++;
            do_upd(32'h100, (i % 2 == 0), 32'h40, exp[i]);
        end
        look(32'h100);
        n_total++;
        if (o_pred_taken !== exp_final) $display("FAIL alt_final got=%0b exp=%0b", o_pred_taken, exp_final);
        else n_pass++;
        n_total++;
        if (o_br_cnt !== 32'd8) $display("FAIL alt_br_cnt got=%0d exp=8", o_br_cnt);
        else n_pass++;
        n_total++;
        if (o_miss_cnt !== exp_miss) $display("FAIL alt_miss_cnt got=%0d exp=%0d", o_miss_cnt, exp_miss);
        else n_pass++;
    endtask

    initial begin
        i_rst        = 1'b1;
        i_pc_f       = '0;
        i_upd_vld    = 1'b0;
        i_upd_pc     = '0;
        i_upd_taken  = 1'b0;
        i_upd_target = '0;
        i_upd_pred   = 1'b0;
        test_reset();
        test_allocate();
        test_counter();
        test_alias();
        test_no_alloc();
        test_same_cycle();
        test_alternating();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
